horner_poly_eval: RTL and testbench

- Sequential polynomial evaluator for the accelerator's fixed-point datapath.
- Computes y = c[n]·x^n + … + c[1]·x + c[0] by Horner's rule.
- Drives the combinational Q10.21 multiplier stage and consumes its truncated 32-bit product, one Horner step per clock.
- All data words are 32-bit Q10.21 (1 sign, 10 integer, 21 fraction); 1.0 = 0x00200000.

---
 rtl/horner_poly_eval_if.sv | 36 +++
 rtl/horner_poly_eval.sv | 119 +++++++++++
 tb/tb_horner_poly_eval.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/horner_poly_eval_if.sv
// Bus bundle for horner_poly_eval: coefficient load, x request, external
// multiplier hookup, y result, plus an FSM state debug tap.
interface horner_poly_eval_if #(
  parameter int DW = 32,
  parameter int AW = 3
);
  // Both x and y handshakes transfer on a rising clk edge where valid && ready;
  // the producer holds valid and data stable until that edge.
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [DW-1:0] coef_data;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic [AW-1:0] degree;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [DW-1:0] mul_result;
  logic          y_valid;
  logic          y_ready;
  logic [DW-1:0] y_data;
  logic          y_ovf;
  logic [1:0]    fsm_state;

  modport master (
    output coef_we, coef_addr, coef_data, x_valid, x_data, degree,
           mul_result, y_ready,
    input  x_ready, mul_a, mul_b, y_valid, y_data, y_ovf, fsm_state
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, x_valid, x_data, degree,
           mul_result, y_ready,
    output x_ready, mul_a, mul_b, y_valid, y_data, y_ovf, fsm_state
  );
endinterface

// File: rtl/horner_poly_eval.sv
// Sequential Horner polynomial evaluator on Q10.21 words, one step per clock.
// Define HORNER_SAT_EN for saturating adds with a sticky overflow flag.
module horner_poly_eval #(
  parameter int MAX_DEGREE = 7,
  parameter int DW         = 32,
  parameter int AW         = 3
) (
  input logic               clk,
  input logic               rst_n,
  horner_poly_eval_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] coef [MAX_DEGREE+1];
  logic [DW-1:0] acc;
  logic [DW-1:0] x_reg;
  logic [AW-1:0] idx;
  logic          ovf;
  logic          x_ready_r;
  logic          y_valid_r;

  logic          accept;
  logic          coef_wr;
  logic [AW-1:0] deg_c;
  logic [DW-1:0] coef_idx;
  logic [DW-1:0] sum;
  logic [DW-1:0] add_res;
  logic          add_ovf;

  assign accept   = x_ready_r && bus.x_valid;
  assign deg_c    = (int'(bus.degree) > MAX_DEGREE) ? AW'(MAX_DEGREE) : bus.degree;
  // A write loses to a same-cycle accept so the evaluation sees a stable file.
  assign coef_wr  = (state == IDLE) && !accept && bus.coef_we &&
                    (int'(bus.coef_addr) <= MAX_DEGREE);
  assign coef_idx = coef[idx];
  assign sum      = bus.mul_result + coef_idx;

`ifdef HORNER_SAT_EN
  assign add_ovf = (bus.mul_result[DW-1] == coef_idx[DW-1]) &&
                   (sum[DW-1] != bus.mul_result[DW-1]);
  assign add_res = !add_ovf ? sum :
                   bus.mul_result[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
  assign add_ovf = 1'b0;
  assign add_res = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      x_reg     <= '0;
      idx       <= '0;
      ovf       <= 1'b0;
      x_ready_r <= 1'b1;
      y_valid_r <= 1'b0;
      for (int i = 0; i <= MAX_DEGREE; i++) begin
        coef[i] <= '0;
      end
    end else begin
      if (coef_wr) begin
        coef[bus.coef_addr] <= bus.coef_data;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            x_reg     <= bus.x_data;
            acc       <= coef[deg_c];
            idx       <= deg_c - 1'b1;
            ovf       <= 1'b0;
            x_ready_r <= 1'b0;
            if (deg_c == '0) begin
              state     <= DONE;
              y_valid_r <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= add_res;
          ovf <= ovf | add_ovf;
          if (idx == '0) begin
            state     <= DONE;
            y_valid_r <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.y_ready) begin
            state     <= IDLE;
            y_valid_r <= 1'b0;
            x_ready_r <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          y_valid_r <= 1'b0;
          x_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Multiplier operands come straight from registers; its product returns in the same cycle.
  assign bus.mul_a     = acc;
  assign bus.mul_b     = x_reg;
  assign bus.x_ready   = x_ready_r;
  assign bus.y_valid   = y_valid_r;
  assign bus.y_data    = acc;
  assign bus.y_ovf     = ovf && y_valid_r;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_horner_poly_eval.sv
// Self-checking bench for horner_poly_eval: directed cases plus randomized
// evaluations scored against a behavioural Horner model.
module tb_horner_poly_eval;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int MAXD = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  horner_poly_eval_if #(.DW(DW), .AW(AW)) bif ();

  horner_poly_eval #(.MAX_DEGREE(MAXD), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Combinational Q10.21 multiplier: full signed product, keep bits [52:21].
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[52:21];
  endfunction

  assign bif.mul_result = qmul(bif.mul_a, bif.mul_b);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_coef [MAXD+1];
  logic [DW:0]   exp_q[$];
  bit            busy = 0;
  int            k = 0;
  int            cur_n = 0;
  logic [DW-1:0] cur_x = '0;
  int            n_done = 0;
  int            n_req = 0;
  logic [DW-1:0] last_y = '0;
  logic          last_ovf = 1'b0;

  function automatic logic [DW:0] model_eval(input logic [DW-1:0] x, input int n);
    logic [DW-1:0] acc;
    logic          ovf;
    longint        s;
    acc = m_coef[n];
    ovf = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      s = longint'($signed(qmul(acc, x))) + longint'($signed(m_coef[i]));
`ifdef HORNER_SAT_EN
      if (s > 64'sd2147483647) begin
        acc = 32'h7FFFFFFF; ovf = 1'b1;
      end else if (s < -64'sd2147483648) begin
        acc = 32'h80000000; ovf = 1'b1;
      end else begin
        acc = s[31:0];
      end
`else
      acc = s[31:0];
`endif
    end
    return {ovf, acc};
  endfunction

  // ---------------- compare process ----------------
  initial begin
    for (int i = 0; i <= MAXD; i++) m_coef[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_x_ready", bif.x_ready, 1);
        check("rst_y_valid", bif.y_valid, 0);
        check("rst_y_data",  bif.y_data, 0);
        check("rst_y_ovf",   bif.y_ovf, 0);
        check("rst_mul_a",   bif.mul_a, 0);
        check("rst_mul_b",   bif.mul_b, 0);
        busy = 0;
        k = 0;
        exp_q.delete();
        for (int i = 0; i <= MAXD; i++) m_coef[i] = '0;
      end else begin
        bit exp_yv;
        if (busy) k++;
        exp_yv = busy && (k >= cur_n + 1);
        check("x_ready", bif.x_ready, !busy);
        check("y_valid", bif.y_valid, exp_yv);
        if (busy) check("mul_b", bif.mul_b, cur_x);
        if (exp_yv && exp_q.size() > 0) begin
          check("y_data", bif.y_data, exp_q[0][DW-1:0]);
          check("y_ovf",  bif.y_ovf, exp_q[0][DW]);
        end
        if (exp_yv && bif.y_ready) begin
          last_y   = bif.y_data;
          last_ovf = bif.y_ovf;
          n_done++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          busy = 0;
        end else if (!busy && bif.x_valid) begin
          busy  = 1;
          k     = 0;
          cur_n = int'(bif.degree);
          cur_x = bif.x_data;
          exp_q.push_back(model_eval(bif.x_data, cur_n));
        end else if (!busy && bif.coef_we) begin
          m_coef[bif.coef_addr] = bif.coef_data;
        end
      end
    end
  end

  // ---------------- y_ready driver ----------------
  bit yr_rand  = 0;
  bit yr_fixed = 1;
  initial begin
    bif.y_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bif.y_ready = yr_rand ? 1'($urandom_range(0, 1)) : yr_fixed;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.coef_we   = 1'b1;
    bif.coef_addr = a;
    bif.coef_data = d;
    tick();
    bif.coef_we   = 1'b0;
  endtask

  task automatic eval(input logic [DW-1:0] x, input logic [AW-1:0] n);
    int guard = 0;
    while (!bif.x_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("eval_ready_timeout", guard < 100, 1);
    bif.x_valid = 1'b1;
    bif.x_data  = x;
    bif.degree  = n;
    tick();
    bif.x_valid = 1'b0;
    n_req++;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (n_done < n_req && guard < 200) begin
      tick();
      guard++;
    end
    check("done_timeout", n_done >= n_req, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bif.coef_we   = 1'b0;
    bif.coef_addr = '0;
    bif.coef_data = '0;
    bif.x_valid   = 1'b0;
    bif.x_data    = '0;
    bif.degree    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Basic: 3x^2 + 2x + 1 at x = 2.0 -> 17.0
    write_coef(3'd0, 32'h00200000);
    write_coef(3'd1, 32'h00400000);
    write_coef(3'd2, 32'h00600000);
    eval(32'h00400000, 3'd2);
    wait_done();
    check("basic_lit", last_y, 32'h02200000);

    // Degree zero returns c0 directly
    write_coef(3'd0, 32'h00600000);
    eval($urandom, 3'd0);
    wait_done();
    check("deg0_lit", last_y, 32'h00600000);
    write_coef(3'd0, 32'h00200000);

    // Backpressure with a rejected request during DONE
    yr_fixed = 0;
    eval(32'h00400000, 3'd2);
    repeat (2) tick();
    bif.x_valid = 1'b1;
    bif.x_data  = $urandom;
    bif.degree  = 3'd1;
    repeat (5) tick();
    bif.x_valid = 1'b0;
    yr_fixed = 1;
    wait_done();
    check("bp_lit", last_y, 32'h02200000);
    repeat (2) tick();
    check("bp_no_extra", n_done, n_req);

    // Write lockout during RUN
    eval(32'h00400000, 3'd2);
    write_coef(3'd0, 32'h7FFFFFFF);
    wait_done();
    check("lockout_lit", last_y, 32'h02200000);
    eval($urandom, 3'd0);
    wait_done();
    check("lockout_c0", last_y, 32'h00200000);

    // Asynchronous reset in the middle of RUN
    eval(32'h00400000, 3'd2);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_req = n_done;
    repeat (4) tick();
    eval(32'h00400000, 3'd2);
    wait_done();
    check("rst_coef_clear", last_y, 32'h00000000);

    // Overflow on the Horner add
    write_coef(3'd1, 32'h00200000);
    write_coef(3'd0, 32'h10000000);
    eval(32'h7F000000, 3'd1);
    wait_done();
`ifdef HORNER_SAT_EN
    check("ovf_y_lit", last_y, 32'h7FFFFFFF);
    check("ovf_flag_lit", last_ovf, 1);
`else
    check("ovf_y_lit", last_y, 32'h8F000000);
    check("ovf_flag_lit", last_ovf, 0);
`endif

    // Randomized evaluations with random backpressure and stray writes
    yr_rand = 1;
    repeat (40) begin
      repeat ($urandom_range(0, 3)) write_coef(3'($urandom_range(0, 7)), $urandom);
      eval($urandom, 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) write_coef(3'($urandom_range(0, 7)), $urandom);
      wait_done();
    end
    yr_rand = 0;
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    check("all_done", n_done, n_req);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
